// File: rtl/vram_arbiter.sv
// Text-mode VRAM arbiter: interleaves character-code fetches for the display
// with host read/write accesses on a single-port synchronous RAM.
module vram_arbiter #(
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned COLS     = 80
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [11:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic        ram_en,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  char_code,
  output logic [3:0]  glyph_row
);

  localparam int unsigned PW = 10;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;
  localparam int unsigned GW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            host_ack_q, host_ack_d;
  logic [DW-1:0]   host_rdata_q, host_rdata_d;
  logic [DW-1:0]   char_code_q, char_code_d;
  logic [GW-1:0]   glyph_row_q, glyph_row_d;
  logic [AW-1:0]   row_base_q, row_base_d;
  logic            fetch_pend_q, fetch_pend_d;

  logic [PW-1:0]   next_line;
  logic            line_end;
  logic            slot_eol;
  logic            slot_col;
  logic            fetch_slot;
  logic [AW-1:0]   fetch_addr;
  logic            host_grant;

  // Fetch-slot decode: end-of-line prefetch of column 0, or mid-line column fetch.
  always_comb begin
    next_line  = (vpos == PW'(V_TOTAL - 1)) ? '0 : vpos + PW'(1);
    line_end   = (hpos == PW'(H_TOTAL - 2));
    slot_eol   = line_end && (next_line < PW'(V_ACTIVE));
    slot_col   = (hpos[2:0] == 3'd6) && (hpos < PW'(H_ACTIVE - 8)) &&
                 (vpos < PW'(V_ACTIVE));
    fetch_slot = slot_eol || slot_col;
  end

  // Row counters advance at line end; the prefetch uses the post-update base.
  always_comb begin
    glyph_row_d = glyph_row_q;
    row_base_d  = row_base_q;
    if (line_end) begin
      if (next_line == '0) begin
        glyph_row_d = '0;
        row_base_d  = '0;
      end else begin
        glyph_row_d = glyph_row_q + GW'(1);
        if (glyph_row_q == GW'(15)) begin
          row_base_d = row_base_q + AW'(COLS);
        end
      end
    end
    if (slot_eol) begin
      fetch_addr = row_base_d;
    end else begin
      fetch_addr = row_base_q + AW'(hpos[9:3]) + AW'(1);
    end
  end

  // Host FSM next-state and host-side register inputs; fetch slots take priority.
  always_comb begin
    state_d      = state_q;
    host_grant   = 1'b0;
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (host_req && !fetch_slot) begin
          host_grant = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        host_rdata_d = ram_rdata;
        host_ack_d   = 1'b1;
        state_d      = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // RAM port mux: display fetch, host grant, or idle.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (fetch_slot) begin
      ram_en   = 1'b1;
      ram_addr = fetch_addr;
    end else if (host_grant) begin
      ram_en    = 1'b1;
      ram_we    = host_we;
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
    end
  end

  // Character code captures RAM data the cycle after a fetch slot.
  always_comb begin
    fetch_pend_d = fetch_slot;
    char_code_d  = fetch_pend_q ? ram_rdata : char_code_q;
  end

  // State and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
      char_code_q  <= '0;
      glyph_row_q  <= '0;
      row_base_q   <= '0;
      fetch_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
      char_code_q  <= char_code_d;
      glyph_row_q  <= glyph_row_d;
      row_base_q   <= row_base_d;
      fetch_pend_q <= fetch_pend_d;
    end
  end

  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;
  assign char_code  = char_code_q;
  assign glyph_row  = glyph_row_q;

endmodule
